// File: rtl/simon_decrypt_pkg.sv
// simon_decrypt_pkg
//   Shared sizing, FSM encoding and SIMON32/64 helper functions for the
//   decryptor and its inverse-round datapath.
//   N : word size in bits (block is 2N)
//   M : number of master key words
//   T : number of rounds
package simon_decrypt_pkg;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int T  = 32;
  localparam int CW = $clog2(T);

  typedef logic [N-1:0] word_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_KEYGEN = 2'd1;
  localparam logic [1:0] ST_ROUND  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Element 0 of the z0 sequence is the leftmost character, i.e. bit 61.
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic word_t rol(input word_t v, input int unsigned s);
    return word_t'((v << s) | (v >> (N - s)));
  endfunction

  function automatic word_t ror(input word_t v, input int unsigned s);
    return word_t'((v >> s) | (v << (N - s)));
  endfunction

  function automatic word_t simon_f(input word_t v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  function automatic logic z0_bit(input int j);
    return Z0[6'(61 - (j % 62))];
  endfunction

  // One key-schedule step for the M=4 schedule:
  //   k1 = k[i-1], k3 = k[i-3], km = k[i-M], j = i-M.
  function automatic word_t key_next(input word_t k1, input word_t k3,
                                     input word_t km, input int j);
    word_t tmp;
    tmp = ror(k1, 3) ^ k3;
    tmp = tmp ^ ror(tmp, 1);
    return ~km ^ tmp ^ {{(N-1){1'b0}}, z0_bit(j)} ^ word_t'(3);
  endfunction

endpackage

// File: rtl/simon_round_inv.sv
// simon_round_inv
//   One combinational SIMON inverse round.
//   x, y   : current state words
//   k      : round key for this round
//   x_n    : previous-round x  (= y)
//   y_n    : previous-round y  (= x ^ f(y) ^ k)
module simon_round_inv
  import simon_decrypt_pkg::*;
(
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] k,
  output logic [N-1:0] x_n,
  output logic [N-1:0] y_n
);

  assign x_n = y;
  assign y_n = x ^ simon_f(y) ^ k;

endmodule

// File: rtl/simon_decrypt.sv
// simon_decrypt
//   Iterative SIMON32/64 decryptor. Expands the round keys into a key file
//   (skipped when the same key was expanded last time), then runs T inverse
//   rounds, one per clock, from k[T-1] down to k[0].
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   en         : start strobe, honoured only in IDLE
//   ciphertext : {x, y} block to decrypt
//   key        : {k[M-1], ..., k[0]} master key
//   plaintext  : result register, held until the next completion
//   done       : one-cycle completion pulse
//   busy       : high while expanding keys or running rounds
module simon_decrypt
  import simon_decrypt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2*N-1:0]   ciphertext,
  input  logic [N*M-1:0]   key,
  output logic [2*N-1:0]   plaintext,
  output logic             done,
  output logic             busy
);

  logic [1:0]     state;
  logic [CW-1:0]  ctr;        // key index i in KEYGEN, round index idx in ROUND
  word_t          x, y;
  logic [N*M-1:0] key_reg;
  logic           valid;
  word_t          key_file [T];

  logic  cache_hit;
  word_t kg_word;
  word_t x_n, y_n;

  assign cache_hit = valid && (key == key_reg);
  assign busy      = (state == ST_KEYGEN) || (state == ST_ROUND);

  // Index arithmetic wraps in CW bits; out-of-range reads outside KEYGEN are
  // never used.
  assign kg_word = key_next(key_file[ctr - CW'(1)],
                            key_file[ctr - CW'(3)],
                            key_file[ctr - CW'(M)],
                            int'(ctr) - M);

  simon_round_inv u_round (
    .x   (x),
    .y   (y),
    .k   (key_file[ctr]),
    .x_n (x_n),
    .y_n (y_n)
  );

  // NOTE: the key file has no reset; its contents are only trusted while
  // valid is set, and valid is cleared by reset, so a reset would only cost
  // flops and routing.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && en && !cache_hit) begin
      for (int j = 0; j < M; j++) key_file[j] <= key[j*N +: N];
    end else if (state == ST_KEYGEN) begin
      key_file[ctr] <= kg_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ctr       <= '0;
      x         <= '0;
      y         <= '0;
      key_reg   <= '0;
      valid     <= 1'b0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      // NOTE: done defaults low every edge so any set below is a single
      // cycle pulse; all state here uses non-blocking assignment so every
      // branch sees pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            x       <= ciphertext[2*N-1:N];
            y       <= ciphertext[N-1:0];
            key_reg <= key;
            if (cache_hit) begin
              ctr   <= CW'(T - 1);
              state <= ST_ROUND;
            end else begin
              valid <= 1'b0;
              ctr   <= CW'(M);
              state <= ST_KEYGEN;
            end
          end
        end
        ST_KEYGEN: begin
          // ctr already holds T-1 on the last write, which is where ROUND starts.
          if (ctr == CW'(T - 1)) begin
            valid <= 1'b1;
            state <= ST_ROUND;
          end else begin
            ctr <= ctr + CW'(1);
          end
        end
        ST_ROUND: begin
          x <= x_n;
          y <= y_n;
          if (ctr == '0) begin
            plaintext <= {x_n, y_n};
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            ctr <= ctr - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_decrypt.sv
// tb_simon_decrypt
//   Scoreboard bench for simon_decrypt. Expected plaintext and latency are
//   queued when an operation is started and compared when done is seen.
//   Expected plaintexts come from spec vectors or from an independent
//   forward (encrypting) SIMON32/64 model.
module tb_simon_decrypt;

  localparam logic [63:0] KEY_A = 64'h1918111009080100;
  localparam logic [61:0] ZSEQ  =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] ciphertext;
  logic [63:0] key;
  logic [31:0] plaintext;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pt;
    int          lat;
  } exp_t;

  exp_t sb[$];

  simon_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ciphertext (ciphertext),
    .key        (key),
    .plaintext  (plaintext),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- forward reference model ----------------
  function automatic logic [15:0] m_rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] m_ror(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [31:0] model_encrypt(input logic [31:0] pt,
                                                input logic [63:0] k);
    logic [15:0] ks [32];
    logic [15:0] xa, ya, tmp, t;
    logic [61:0] z;
    z = ZSEQ;
    for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp   = m_ror(ks[i-1], 3) ^ ks[i-3];
      tmp   = tmp ^ m_ror(tmp, 1);
      ks[i] = ~ks[i-4] ^ tmp ^ {15'b0, z[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
    xa = pt[31:16];
    ya = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t  = xa;
      xa = ya ^ (m_rol(xa, 1) & m_rol(xa, 8)) ^ m_rol(xa, 2) ^ ks[i];
      ya = t;
    end
    return {xa, ya};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start strobe; returns just after the sampling edge. Inputs are
  // scrambled afterwards to show the DUT latched them.
  task automatic start_op(input logic [31:0] ct, input logic [63:0] k);
    ciphertext = ct;
    key        = k;
    en         = 1'b1;
    tick();
    en         = 1'b0;
    ciphertext = ~ct;
    key        = ~k;
  endtask

  task automatic push_exp(input logic [31:0] pt, input int lat);
    exp_t e;
    e.pt  = pt;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits for done (bounded), then pops and compares. Optionally pulses en
  // at a given cycle of the operation and/or during the DONE cycle.
  task automatic finish_op(input string tag, input int inject_cyc,
                           input bit inject_in_done);
    int   cyc;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    cyc      = 0;
    seen     = 1'b0;
    busy_cnt = busy ? 1 : 0;
    while (!seen && cyc < 200) begin
      if (cyc == inject_cyc) begin
        en         = 1'b1;
        ciphertext = 32'h0badf00d;
      end
      tick();
      en = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    e = sb.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
    check({tag, "_plaintext"}, 64'(plaintext), 64'(e.pt));
    if (inject_in_done) begin
      en         = 1'b1;
      ciphertext = 32'hdeadbeef;
      tick();
      en = 1'b0;
      check({tag, "_done_drops"}, 64'(done), 64'd0);
      check({tag, "_idle_after_done"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] ct, pt_rand, pt_hold;
    int          extra;

    rst        = 1'b1;
    en         = 1'b0;
    ciphertext = '0;
    key        = '0;
    tick();
    tick();
    check("reset_plaintext", 64'(plaintext), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Known vector, cache miss.
    push_exp(32'h65656877, 60);
    start_op(32'hc69be9bb, KEY_A);
    finish_op("known_miss", -1, 1'b0);
    tick();

    // Same key again, en in the cycle after DONE: cache hit.
    push_exp(32'h65656877, 32);
    start_op(32'hc69be9bb, KEY_A);
    finish_op("known_hit", -1, 1'b0);
    tick();

    // Round trip of 23451 through the forward model.
    ct = model_encrypt(32'd23451, KEY_A);
    push_exp(32'h00005b9b, 32);
    start_op(ct, KEY_A);
    finish_op("round_trip", -1, 1'b0);
    tick();

    // Key change to all zeros: keygen reruns.
    pt_rand = $urandom;
    ct      = model_encrypt(pt_rand, 64'h0);
    push_exp(pt_rand, 60);
    start_op(ct, 64'h0);
    finish_op("key_zero", -1, 1'b0);
    tick();

    // Ignored strobes at cycle 10 and during DONE.
    pt_rand = $urandom;
    ct      = model_encrypt(pt_rand, 64'h0);
    push_exp(pt_rand, 32);
    start_op(ct, 64'h0);
    finish_op("ignored_en", 10, 1'b1);
    pt_hold = plaintext;
    extra   = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (done || busy) extra++;
    end
    check("ignored_no_extra_activity", 64'(extra), 64'd0);
    check("ignored_plaintext_held", 64'(plaintext), 64'(pt_rand));
    check("ignored_plaintext_stable", 64'(plaintext), 64'(pt_hold));

    // Reset mid-ROUND after KEY_A has been expanded.
    start_op(32'hc69be9bb, KEY_A);
    repeat (40) tick();
    check("mid_round_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_plaintext", 64'(plaintext), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    push_exp(32'h65656877, 60);
    start_op(32'hc69be9bb, KEY_A);
    finish_op("after_reset", -1, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
